// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity selectors, line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic PAR_EVEN   = 1'b0;
    localparam logic PAR_ODD    = 1'b1;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register plus data-bit counter for the UART transmitter.
// o_bit is the bit the line should carry next: the current LSB, or the
// LSB after this cycle's shift when i_shift is asserted.
module uart_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_shift,
    output logic                  o_bit,
    output logic                  o_done
);

    localparam int unsigned      CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [CNT_W-1:0]      cnt_q;

    assign shift_next = shift_q >> 1;
    assign o_done     = (cnt_q == CNT_LAST);

    // Looking one shift ahead lets the registered line output carry bit k+1
    // in the cycle after the shift, so bit 0 can go out straight from START.
    assign o_bit      = i_shift ? shift_next[0] : shift_q[0];

    // Load clears the counter; shifting stops counting at the last bit (no wrap).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (i_load) begin
            shift_q <= i_data;
            cnt_q   <= '0;
        end else if (i_shift && !o_done) begin
            shift_q <= shift_next;
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit.
// One i_clk cycle is one bit period; o_tx and o_busy come straight from flops.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_valid,
    input  logic                  i_par_en,
    input  logic                  i_par_type,
    output logic                  o_tx,
    output logic                  o_busy
);

    tx_state_e             state_q;
    tx_state_e             state_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_type_q;
    logic                  tx_d;
    logic                  busy_d;
    logic                  accept;
    logic                  shift_en;
    logic                  ser_bit;
    logic                  ser_done;
    logic                  parity_bit;

    // New payload is taken only while idle or during the stop bit.
    assign accept     = i_data_valid && ((state_q == IDLE) || (state_q == STOP));
    assign shift_en   = (state_q == DATA) && !ser_done;
    assign parity_bit = (^data_q) ^ (par_type_q == PAR_ODD);

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (accept),
        .i_data  (i_data),
        .i_shift (shift_en),
        .o_bit   (ser_bit),
        .o_done  (ser_done)
    );

    // State register, registered outputs and the per-frame latched settings.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            o_tx       <= LINE_IDLE;
            o_busy     <= 1'b0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= PAR_EVEN;
        end else begin
            state_q <= state_d;
            o_tx    <= tx_d;
            o_busy  <= busy_d;
            if (accept) begin
                data_q     <= i_data;
                par_en_q   <= i_par_en;
                par_type_q <= i_par_type;
            end
        end
    end

    // Next state plus the line/busy values that go with it.
    always_comb begin
        state_d = state_q;
        tx_d    = LINE_IDLE;
        busy_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    tx_d    = LINE_START;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                state_d = DATA;
                tx_d    = ser_bit;
                busy_d  = 1'b1;
            end
            DATA: begin
                busy_d = 1'b1;
                if (ser_done) begin
                    if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = parity_bit;
                    end else begin
                        state_d = STOP;
                        tx_d    = LINE_IDLE;
                    end
                end else begin
                    tx_d = ser_bit;
                end
            end
            PARITY: begin
                state_d = STOP;
                tx_d    = LINE_IDLE;
                busy_d  = 1'b1;
            end
            STOP: begin
                if (accept) begin
                    state_d = START;
                    tx_d    = LINE_START;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx with DATA_WIDTH = 8.
// Inputs change and outputs are sampled on the falling edge.
module tb_uart_tx;

    logic       i_clk;
    logic       i_rst;
    logic [7:0] i_data;
    logic       i_data_valid;
    logic       i_par_en;
    logic       i_par_type;
    logic       o_tx;
    logic       o_busy;

    int errors;
    int checks;

    uart_tx #(
        .DATA_WIDTH (8)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .i_par_en     (i_par_en),
        .i_par_type   (i_par_type),
        .o_tx         (o_tx),
        .o_busy       (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Present a payload for one rising edge; returns in the start-bit cycle.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt);
        i_data       = d;
        i_par_en     = pe;
        i_par_type   = pt;
        i_data_valid = 1'b1;
        @(negedge i_clk);
        i_data_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_rst        = 1'b1;
        i_data       = 8'h3C;
        i_data_valid = 1'b1;
        i_par_en     = 1'b0;
        i_par_type   = 1'b0;
        idle_cycles(2);
        checks++;
        if (o_tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx: got %b expected 1", o_tx);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", o_busy);
        end
        i_rst        = 1'b0;
        i_data_valid = 1'b0;
        idle_cycles(1);
        checks++;
        if (o_tx !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority: got tx=%b busy=%b expected tx=1 busy=0", o_tx, o_busy);
        end
        idle_cycles(1);
    endtask

    task automatic test_no_parity();
        logic [9:0] exp_bits;
        exp_bits = 10'b0101001011; // 0xA5: start, 1,0,1,0,0,1,0,1, stop
        send(8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (o_tx !== exp_bits[9-i]) begin
                errors++;
                $display("FAIL nopar_tx[%0d]: got %b expected %b", i, o_tx, exp_bits[9-i]);
            end
            checks++;
            if (o_busy !== 1'b1) begin
                errors++;
                $display("FAIL nopar_busy[%0d]: got %b expected 1", i, o_busy);
            end
            @(negedge i_clk);
        end
        checks++;
        if (o_busy !== 1'b0 || o_tx !== 1'b1) begin
            errors++;
            $display("FAIL nopar_end: got tx=%b busy=%b expected tx=1 busy=0", o_tx, o_busy);
        end
        idle_cycles(2);
    endtask

    task automatic test_parity();
        logic [7:0]  vd [4];
        logic        vt [4];
        logic [10:0] ve [4];
        vd[0] = 8'hA5; vt[0] = 1'b0; ve[0] = 11'b01010010101; // even -> 0
        vd[1] = 8'hA5; vt[1] = 1'b1; ve[1] = 11'b01010010111; // odd  -> 1
        vd[2] = 8'h01; vt[2] = 1'b0; ve[2] = 11'b01000000011; // even -> 1
        vd[3] = 8'h00; vt[3] = 1'b1; ve[3] = 11'b00000000011; // odd  -> 1
        for (int v = 0; v < 4; v++) begin
            send(vd[v], 1'b1, vt[v]);
            for (int i = 0; i < 11; i++) begin
                checks++;
                if (o_tx !== ve[v][10-i] || o_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL par%0d_bit[%0d]: got tx=%b busy=%b expected tx=%b busy=1",
                             v, i, o_tx, o_busy, ve[v][10-i]);
                end
                // Settings flipped mid-frame must not reach the current frame.
                if (i == 3) begin
                    i_par_type = ~vt[v];
                    i_par_en   = 1'b0;
                end
                @(negedge i_clk);
            end
            checks++;
            if (o_busy !== 1'b0 || o_tx !== 1'b1) begin
                errors++;
                $display("FAIL par%0d_end: got tx=%b busy=%b expected tx=1 busy=0", v, o_tx, o_busy);
            end
            idle_cycles(2);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp_bits;
        exp_bits = 20'b01010101010111100001; // 0x55 frame then 0x0F frame
        send(8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (o_tx !== exp_bits[19-i] || o_busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_bit[%0d]: got tx=%b busy=%b expected tx=%b busy=1",
                         i, o_tx, o_busy, exp_bits[19-i]);
            end
            if (i == 9) begin
                i_data       = 8'h0F;
                i_data_valid = 1'b1;
            end
            @(negedge i_clk);
            if (i == 9) i_data_valid = 1'b0;
        end
        checks++;
        if (o_busy !== 1'b0 || o_tx !== 1'b1) begin
            errors++;
            $display("FAIL b2b_end: got tx=%b busy=%b expected tx=1 busy=0", o_tx, o_busy);
        end
        idle_cycles(2);
    endtask

    task automatic test_ignored_valid();
        logic [9:0] exp_bits;
        exp_bits = 10'b0000000001;
        send(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (o_tx !== exp_bits[9-i] || o_busy !== 1'b1) begin
                errors++;
                $display("FAIL ign_bit[%0d]: got tx=%b busy=%b expected tx=%b busy=1",
                         i, o_tx, o_busy, exp_bits[9-i]);
            end
            if (i == 3) begin
                i_data       = 8'hFF;
                i_data_valid = 1'b1;
            end
            @(negedge i_clk);
            if (i == 3) i_data_valid = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o_busy !== 1'b0 || o_tx !== 1'b1) begin
                errors++;
                $display("FAIL ign_idle[%0d]: got tx=%b busy=%b expected tx=1 busy=0", i, o_tx, o_busy);
            end
            @(negedge i_clk);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] exp_bits;
        send(8'hA5, 1'b0, 1'b0);
        idle_cycles(4); // now in the 4th data bit
        checks++;
        if (o_tx !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: got tx=%b busy=%b expected tx=0 busy=1", o_tx, o_busy);
        end
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        checks++;
        if (o_tx !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_abort: got tx=%b busy=%b expected tx=1 busy=0", o_tx, o_busy);
        end
        idle_cycles(2);
        checks++;
        if (o_tx !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle: got tx=%b busy=%b expected tx=1 busy=0", o_tx, o_busy);
        end
        exp_bits = 11'b00011110001; // 0x3C even parity -> 0
        send(8'h3C, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (o_tx !== exp_bits[10-i] || o_busy !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_frame[%0d]: got tx=%b busy=%b expected tx=%b busy=1",
                         i, o_tx, o_busy, exp_bits[10-i]);
            end
            @(negedge i_clk);
        end
        checks++;
        if (o_busy !== 1'b0 || o_tx !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_end: got tx=%b busy=%b expected tx=1 busy=0", o_tx, o_busy);
        end
        idle_cycles(2);
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        i_rst        = 1'b1;
        i_data       = '0;
        i_data_valid = 1'b0;
        i_par_en     = 1'b0;
        i_par_type   = 1'b0;
        @(negedge i_clk);
        test_reset();
        test_no_parity();
        test_parity();
        test_back_to_back();
        test_ignored_valid();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter clocked directly by the divided baud clock produced by the clock divider; one `i_clk` cycle equals one bit period. Accepts a parallel byte with a single-cycle valid strobe and emits a frame on `o_tx`: start bit, data bits LSB first, optional parity bit, stop bit. Sits between the register file/FIFO read side and the TX pin.

## Interface
- `DATA_WIDTH`, default 8: payload bits per frame.
- `i_clk`  in  1  divided baud clock from the clock divider; one bit per cycle.
- `i_rst`  in  1  synchronous reset, active-high.
- `i_data`  in  DATA_WIDTH  payload; sampled only when accepted.
- `i_data_valid`  in  1  payload strobe; accepted only in IDLE, or in the STOP cycle.
- `i_par_en`  in  1  1 = insert parity bit; sampled with `i_data`.
- `i_par_type`  in  1  0 = even, 1 = odd; sampled with `i_data`.
- `o_tx`  out  1  serial line, registered; idle high.
- `o_busy`  out  1  registered; high from the start-bit cycle through the stop-bit cycle.

## Operation
- Clock: one clock, `i_clk`. Reset: synchronous, active-high, on `i_rst`.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `o_tx`=1 and `o_busy`=0. On `i_data_valid`=1, latch `i_data`, `i_par_en` and `i_par_type`, then go to START.
- START: `o_tx`=0 and `o_busy`=1. Go to DATA.
- DATA: `o_tx` = shift_reg[0]. Shift right each cycle. After DATA_WIDTH cycles, go to PARITY if latched par_en=1, else to STOP.
- Bit counter: $clog2(DATA_WIDTH) bits; compares against DATA_WIDTH-1; no wrap beyond it.
- PARITY: `o_tx` = ^data XOR par_type. Parity is computed on the latched byte, not the shifted register. Go to STOP.
- STOP: `o_tx`=1 and `o_busy`=1.
  - If `i_data_valid`=1 in this cycle: latch the new payload and go to START (back-to-back; no idle bit).
  - Otherwise go to IDLE.
- `i_data_valid` during START, DATA or PARITY is ignored. The payload is dropped and there is no error flag; the upstream side must gate on `o_busy`.
- Changes to `i_par_en` or `i_par_type` mid-frame have no effect on the current frame.
- Reset mid-frame: the frame is aborted. In the next cycle `o_tx`=1, `o_busy`=0, the FSM is in IDLE, and the counter and shift register are cleared.
- Reset values: `o_tx`=1, `o_busy`=0, state IDLE, counter 0, shift register 0.
- Reset has priority over `i_data_valid` in the same cycle.

## Timing
- Valid sampled at edge N (in IDLE): start bit on `o_tx` for cycle N+1.
- Data bit k is on `o_tx` for cycle N+2+k, k = 0..DATA_WIDTH-1.
- Parity bit (if enabled) in cycle N+2+DATA_WIDTH, then the stop bit. Without parity, the stop bit is in cycle N+2+DATA_WIDTH.
- Frame length: DATA_WIDTH+2 cycles, or DATA_WIDTH+3 with parity.
- `o_busy` rises together with the start bit and falls in the cycle after the stop bit, unless back-to-back.
- Back-to-back throughput: one frame every DATA_WIDTH+2 (or +3) cycles, with no gap.
- All outputs come straight from flops; no combinational path from inputs to outputs.

## Structure
- Shared package `uart_pkg`:
  - TX state enum (IDLE/START/DATA/PARITY/STOP).
  - Parity constants PAR_EVEN=0 and PAR_ODD=1.
  - Line level constants LINE_IDLE=1 and LINE_START=0.
- Sub-module `uart_tx_serializer`: latch/shift register plus bit counter. Inputs: load, shift enable. Outputs: serial bit, done flag.
- FSM, parity computation and output mux stay in `uart_tx`.

## Test plan
- 0xA5, par_en=0: after valid, `o_tx` sequence is 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop). `o_busy` is high for exactly 10 cycles.
- 0xA5, par_en=1, even parity: parity bit = 0 and the frame is 11 cycles. Repeat with odd parity: parity bit = 1.
- 0x01 with even parity gives parity 1. 0x00 with odd parity gives parity 1. Check the latched par_type is used even when the input toggles mid-frame.
- Back-to-back: 0x55 then 0x0F, with valid asserted again in the STOP cycle. The second start bit immediately follows the stop bit, and `o_busy` never drops across the 20 cycles.
- Valid pulsed with 0xFF during the DATA bits of a 0x00 frame: the line shows all-zero data, the frame ends normally, and 0xFF is never transmitted.
- `i_rst` asserted in the 4th data bit: next cycle `o_tx`=1 and `o_busy`=0. A new valid after reset produces a clean full frame.
